// File: rtl/sp3_demux_pkg.sv
// Shared types and helpers for the SPROCKET3 uplink deinterleaver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sp3_demux_pkg;

  localparam int SP3_W_DEFAULT   = 32;
  localparam int SP3_NCH_DEFAULT = 2;

  // Fine-slip amount for the default word width.
  typedef logic [$clog2(SP3_W_DEFAULT)-1:0] slip_t;

  // Destination of one interleaved bit after deinterleaving.
  typedef struct packed {
    int unsigned ch;   // output channel
    int unsigned pos;  // bit position inside that channel's W-bit word
  } dil_map_t;

  // Bit i of group word j (j = 0 is the oldest word of the group) goes to
  // channel i mod nch, at position j*(w/nch) + i div nch.
  function automatic dil_map_t deinterleave_bit(input int unsigned i,
                                                input int unsigned j,
                                                input int unsigned nch,
                                                input int unsigned w);
    dil_map_t m;
    m.ch  = i % nch;
    m.pos = j * (w / nch) + i / nch;
    return m;
  endfunction

endpackage

// File: rtl/sp3_bitslip_ctrl.sv
// Per-channel fine-slip controller: wrap-around slip counter with hold-off.
// Latency: an accepted request updates slip_val on the same clock edge.
// Backpressure: requests during hold-off are dropped, never queued.
module sp3_bitslip_ctrl
  import sp3_demux_pkg::*;
#(
  parameter int W       = SP3_W_DEFAULT,
  parameter int HOLDOFF = 16
) (
  input  logic                 mgtclk,
  input  logic                 reset,
  input  logic                 bitslip,
  output logic [$clog2(W)-1:0] slip_val,
  output logic                 slip_busy
);

  localparam int SW = $clog2(W);
  localparam int CW = $clog2(HOLDOFF + 1);

  localparam logic [SW-1:0] SLIP_MAX  = SW'(W - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLDOFF);

  logic [SW-1:0] slip_q, slip_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a request only while idle; otherwise run the hold-off down.
  always_comb begin
    slip_d = slip_q;
    cnt_d  = cnt_q;
    if (bitslip && (cnt_q == '0)) begin
      // Wrapping W-1 -> 0 pulls the window back by W-1 bits inside the
      // 2W history, so the stream never gets a twisted word.
      slip_d = (slip_q == SLIP_MAX) ? '0 : slip_q + SW'(1);
      cnt_d  = CNT_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Slip and hold-off state registers.
  always_ff @(posedge mgtclk) begin
    if (reset) begin
      slip_q <= '0;
      cnt_q  <= '0;
    end else begin
      slip_q <= slip_d;
      cnt_q  <= cnt_d;
    end
  end

  assign slip_val  = slip_q;
  assign slip_busy = (cnt_q != '0);

endmodule

// File: rtl/sp3_nch_demux.sv
// N-channel deinterleaver with per-channel bitslip alignment for SPROCKET3 uplinks.
// Latency: hist updates on the edge sampling a group's last word; word_out/word_valid one edge later.
// Backpressure: none; phase_hold drops the current input word and stalls group assembly.
module sp3_nch_demux
  import sp3_demux_pkg::*;
#(
  parameter int NCH     = SP3_NCH_DEFAULT,
  parameter int W       = SP3_W_DEFAULT,
  parameter int HOLDOFF = 16
) (
  input  logic                     mgtclk,
  input  logic                     reset,
  input  logic [W-1:0]             mgtword,
  input  logic                     phase_hold,
  input  logic [NCH-1:0]           bitslip,
  output logic [NCH*W-1:0]         word_out,
  output logic                     word_valid,
  output logic [NCH*$clog2(W)-1:0] slip_val,
  output logic [NCH-1:0]           slip_busy
);

  localparam int SW  = $clog2(W);
  localparam int PHW = (NCH > 1) ? $clog2(NCH) : 1;
  // Only the first NCH-1 words of a group need holding; the last one is
  // used straight off the input on the completing edge.
  localparam int SRN = (NCH > 1) ? NCH - 1 : 1;

  localparam logic [PHW-1:0] PH_LAST = PHW'(NCH - 1);

  // Group phase and slot registers.
  logic [PHW-1:0] ph_q, ph_d;
  logic [W-1:0]   sr_q [SRN];
  logic [W-1:0]   sr_d [SRN];
  logic           grp_done_d, grp_done_q;

  // Flattened group (word j at [j*W +: W]) and its deinterleaved image
  // (channel c at [c*W +: W]).
  logic [NCH*W-1:0] grp;
  logic [NCH*W-1:0] dil;

  // Two-deep history per channel feeding the slip window.
  logic [W-1:0] hist_curr_q [NCH];
  logic [W-1:0] hist_curr_d [NCH];
  logic [W-1:0] hist_prev_q [NCH];
  logic [W-1:0] hist_prev_d [NCH];

  // Output register.
  logic [NCH*W-1:0] word_out_q, word_out_d;
  logic             word_valid_q;
  logic [2*W-1:0]   merged;

  logic [SW-1:0] slip_w [NCH];

  // ---------------------------------------------------------------------
  // Group assembly
  // ---------------------------------------------------------------------

  // Store the sampled word in its slot and advance the phase unless held.
  always_comb begin
    ph_d       = ph_q;
    sr_d       = sr_q;
    grp_done_d = 1'b0;
    if (!phase_hold) begin
      ph_d       = (ph_q == PH_LAST) ? '0 : ph_q + PHW'(1);
      grp_done_d = (ph_q == PH_LAST);
      for (int k = 0; k < SRN; k++) begin
        if (ph_q == PHW'(k)) begin
          sr_d[k] = mgtword;
        end
      end
    end
  end

  // Oldest words come from the slots, the newest from the input port.
  generate
    for (genvar gj = 0; gj < NCH - 1; gj++) begin : g_grp_slot
      assign grp[gj*W +: W] = sr_q[gj];
    end
  endgenerate
  assign grp[(NCH-1)*W +: W] = mgtword;

  // Pure wiring permutation from interleaved group to per-channel words.
  generate
    for (genvar gj = 0; gj < NCH; gj++) begin : g_dil_word
      for (genvar gi = 0; gi < W; gi++) begin : g_dil_bit
        localparam dil_map_t MAP = deinterleave_bit(gi, gj, NCH, W);
        assign dil[MAP.ch*W + MAP.pos] = grp[gj*W + gi];
      end
    end
  endgenerate

  // Shift the channel history on every completed group.
  always_comb begin
    hist_curr_d = hist_curr_q;
    hist_prev_d = hist_prev_q;
    if (grp_done_d) begin
      for (int c = 0; c < NCH; c++) begin
        hist_prev_d[c] = hist_curr_q[c];
        hist_curr_d[c] = dil[c*W +: W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel slip control
  // ---------------------------------------------------------------------

  generate
    for (genvar gc = 0; gc < NCH; gc++) begin : g_slip
      sp3_bitslip_ctrl #(
        .W       (W),
        .HOLDOFF (HOLDOFF)
      ) u_ctrl (
        .mgtclk    (mgtclk),
        .reset     (reset),
        .bitslip   (bitslip[gc]),
        .slip_val  (slip_w[gc]),
        .slip_busy (slip_busy[gc])
      );
      assign slip_val[gc*SW +: SW] = slip_w[gc];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output alignment
  // ---------------------------------------------------------------------

  // Select a W-bit window from {curr, prev} using the slip held before this edge.
  always_comb begin
    word_out_d = word_out_q;
    merged     = '0;
    if (grp_done_q) begin
      for (int c = 0; c < NCH; c++) begin
        merged                 = {hist_curr_q[c], hist_prev_q[c]};
        word_out_d[c*W +: W]   = merged[slip_w[c] +: W];
      end
    end
  end

  // All datapath state; reset drops any partial group.
  always_ff @(posedge mgtclk) begin
    if (reset) begin
      ph_q         <= '0;
      grp_done_q   <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      for (int k = 0; k < SRN; k++) begin
        sr_q[k] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        hist_curr_q[c] <= '0;
        hist_prev_q[c] <= '0;
      end
    end else begin
      ph_q         <= ph_d;
      sr_q         <= sr_d;
      grp_done_q   <= grp_done_d;
      word_out_q   <= word_out_d;
      word_valid_q <= grp_done_q;
      hist_curr_q  <= hist_curr_d;
      hist_prev_q  <= hist_prev_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_sp3_nch_demux.sv
// Bench for sp3_nch_demux: NCH=2 and NCH=4 instances share one stimulus stream.
// A queue-style reference model tracks both; tables and hand sequences cover corner cases.
// Every cycle the outputs of both instances are compared with the model.
module tb_sp3_nch_demux;

  localparam int W  = 32;
  localparam int HO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      = 1'b1;
  logic        phase_hold = 1'b0;
  logic [31:0] mgtword    = '0;
  logic [3:0]  bitslip    = '0;

  logic [63:0]  wo2;
  logic         wv2;
  logic [9:0]   sv2;
  logic [1:0]   sb2;
  logic [127:0] wo4;
  logic         wv4;
  logic [19:0]  sv4;
  logic [3:0]   sb4;

  sp3_nch_demux #(.NCH(2), .W(W), .HOLDOFF(HO)) dut2 (
    .mgtclk(clk), .reset(reset), .mgtword(mgtword), .phase_hold(phase_hold),
    .bitslip(bitslip[1:0]), .word_out(wo2), .word_valid(wv2),
    .slip_val(sv2), .slip_busy(sb2)
  );

  sp3_nch_demux #(.NCH(4), .W(W), .HOLDOFF(HO)) dut4 (
    .mgtclk(clk), .reset(reset), .mgtword(mgtword), .phase_hold(phase_hold),
    .bitslip(bitslip), .word_out(wo4), .word_valid(wv4),
    .slip_val(sv4), .slip_busy(sb4)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // ---------------- reference model (index 0: NCH=2, 1: NCH=4) ----------
  int          mnch [2] = '{2, 4};
  logic [31:0] mw   [2][4];   // words of the group being collected
  int          mn   [2];      // number collected so far
  logic [31:0] mhc  [2][4];
  logic [31:0] mhp  [2][4];
  logic [31:0] meo  [2][4];
  int          ms   [2][4];
  int          mc   [2][4];
  bit          md   [2];
  bit          mev  [2];

  task automatic model_step(input int m);
    logic [63:0] cat;
    logic [31:0] nv;
    int per, jj, ii;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        mhc[m][c] = '0; mhp[m][c] = '0; meo[m][c] = '0;
        ms[m][c] = 0; mc[m][c] = 0;
      end
      mn[m] = 0; md[m] = 0; mev[m] = 0;
      return;
    end
    // output window from history as it stood before this edge
    mev[m] = md[m];
    if (md[m]) begin
      for (int c = 0; c < mnch[m]; c++) begin
        cat = {mhc[m][c], mhp[m][c]};
        cat = cat >> ms[m][c];
        meo[m][c] = cat[31:0];
      end
    end
    for (int c = 0; c < mnch[m]; c++) begin
      if (bitslip[c] && mc[m][c] == 0) begin
        ms[m][c] = (ms[m][c] + 1) % W;
        mc[m][c] = HO;
      end else if (mc[m][c] > 0) begin
        mc[m][c]--;
      end
    end
    md[m] = 0;
    if (!phase_hold) begin
      mw[m][mn[m]] = mgtword;
      mn[m]++;
      if (mn[m] == mnch[m]) begin
        per = W / mnch[m];
        for (int c = 0; c < mnch[m]; c++) begin
          for (int p = 0; p < W; p++) begin
            jj = p / per;
            ii = (p % per) * mnch[m] + c;
            nv[p] = mw[m][jj][ii];
          end
          mhp[m][c] = mhc[m][c];
          mhc[m][c] = nv;
        end
        mn[m] = 0;
        md[m] = 1;
      end
    end
  endtask

  task automatic compare();
    chk("valid2", 32'(wv2), 32'(mev[0]));
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("out2[%0d]", c), wo2[c*32 +: 32], meo[0][c]);
      chk($sformatf("slip2[%0d]", c), 32'(sv2[c*5 +: 5]), 32'(ms[0][c]));
      chk($sformatf("busy2[%0d]", c), 32'(sb2[c]), 32'(mc[0][c] != 0));
    end
    chk("valid4", 32'(wv4), 32'(mev[1]));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("out4[%0d]", c), wo4[c*32 +: 32], meo[1][c]);
      chk($sformatf("slip4[%0d]", c), 32'(sv4[c*5 +: 5]), 32'(ms[1][c]));
      chk($sformatf("busy4[%0d]", c), 32'(sb4[c]), 32'(mc[1][c] != 0));
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; bitslip = '0; phase_hold = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain0(input string nm);
    int t = 0;
    while (sb2[0] && t < 40) begin tick(); t++; end
    chk(nm, 32'(sb2[0]), 32'd0);
  endtask

  task automatic wait_valid2(input string nm);
    int t = 0;
    while (!wv2 && t < 20) begin tick(); t++; end
    chk(nm, 32'(wv2), 32'd1);
  endtask

  // ---------------- constant-pattern table ----------------
  typedef struct packed {
    logic [31:0]      pat;
    logic [1:0][31:0] e2;   // e2[c] = NCH=2 channel c
    logic [3:0][31:0] e4;   // e4[c] = NCH=4 channel c
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n2, n4, busy_cnt, gap;

    // {ch1, ch0} and {ch3, ch2, ch1, ch0}
    tbl[0] = '{32'hAAAAAAAA, {32'hFFFFFFFF, 32'h00000000},
               {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000}};
    tbl[1] = '{32'h11111111, {32'h00000000, 32'h55555555},
               {32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF}};
    tbl[2] = '{32'h22222222, {32'h55555555, 32'h00000000},
               {32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000}};
    tbl[3] = '{32'h0000FFFF, {32'h00FF00FF, 32'h00FF00FF},
               {32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F}};
    tbl[4] = '{32'hFFFF0000, {32'hFF00FF00, 32'hFF00FF00},
               {32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0}};

    // reset state
    do_reset();
    chk("rst out2", wo2[31:0] | wo2[63:32], 32'd0);
    chk("rst valid2", 32'(wv2), 32'd0);
    chk("rst slip4", 32'(sv4), 32'd0);
    chk("rst busy4", 32'(sb4), 32'd0);

    // constant patterns: third valid of the NCH=4 instance after reset
    for (int v = 0; v < 5; v++) begin
      mgtword = tbl[v].pat;
      do_reset();
      n2 = 0; n4 = 0;
      for (int t = 0; t < 13; t++) begin
        tick();
        if (wv2) n2++;
        if (wv4) n4++;
      end
      chk($sformatf("tbl%0d cnt2", v), n2, 6);
      chk($sformatf("tbl%0d cnt4", v), n4, 3);
      chk($sformatf("tbl%0d wv4", v), 32'(wv4), 32'd1);
      for (int c = 0; c < 2; c++)
        chk($sformatf("tbl%0d ch2_%0d", v, c), wo2[c*32 +: 32], tbl[v].e2[c]);
      for (int c = 0; c < 4; c++)
        chk($sformatf("tbl%0d ch4_%0d", v, c), wo4[c*32 +: 32], tbl[v].e4[c]);
    end

    // walking one through the interleaved input
    do_reset();
    for (int k = 0; k < 128; k++) begin
      mgtword = 32'd1 << (k % 32);
      tick();
    end

    // fine slip on channel 0: group words 1,0 then 0,0
    mgtword = '0;
    do_reset();
    bitslip = 4'b0001; mgtword = 32'd1;
    tick();
    chk("fs slip0", 32'(sv2[4:0]), 32'd1);
    bitslip = '0; mgtword = '0;
    tick();
    tick();
    chk("fs valid1", 32'(wv2), 32'd1);
    chk("fs ch0 a", wo2[31:0], 32'h80000000);
    chk("fs ch1 a", wo2[63:32], 32'h00000000);
    tick();
    tick();
    chk("fs ch0 b", wo2[31:0], 32'h00000000);
    chk("fs slip1", 32'(sv2[9:5]), 32'd0);

    // hold-off: level request for 40 cycles
    do_reset();
    busy_cnt = 0;
    bitslip = 4'b0001;
    for (int t = 0; t < 40; t++) begin
      mgtword = $urandom;
      tick();
      if (sb2[0]) busy_cnt++;
    end
    bitslip = '0;
    chk("ho slip", 32'(sv2[4:0]), 32'd3);
    chk("ho busy cycles", busy_cnt, 38);
    drain0("ho drain");
    for (int p = 0; p < 29; p++) begin
      bitslip = 4'b0001; mgtword = $urandom;
      tick();
      bitslip = '0;
      drain0("wrap drain");
      if (p == 27) chk("wrap slip31", 32'(sv2[4:0]), 32'd31);
    end
    chk("wrap slip0", 32'(sv2[4:0]), 32'd0);

    // coarse slip: one phase_hold pulse stretches one interval to 3
    do_reset();
    mgtword = $urandom;
    wait_valid2("cs first valid");
    phase_hold = 1'b1; mgtword = $urandom;
    tick();
    phase_hold = 1'b0;
    gap = 1;
    tick(); gap++;
    while (!wv2 && gap < 10) begin mgtword = $urandom; tick(); gap++; end
    chk("cs gap held", gap, 3);
    gap = 0;
    do begin mgtword = $urandom; tick(); gap++; end while (!wv2 && gap < 10);
    chk("cs gap normal", gap, 2);
    for (int t = 0; t < 12; t++) begin mgtword = $urandom; tick(); end

    // reset mid-group with slip 5 on channel 0
    for (int p = 0; p < 5; p++) begin
      bitslip = 4'b0001; mgtword = $urandom;
      tick();
      bitslip = '0;
      drain0("mr drain");
    end
    chk("mr slip5", 32'(sv2[4:0]), 32'd5);
    tick();
    wait_valid2("mr valid");  // right after a valid, one word of the next group is held
    mgtword = $urandom;
    reset = 1'b1;
    tick();
    chk("mr out2", wo2[31:0] | wo2[63:32], 32'd0);
    chk("mr valid2", 32'(wv2), 32'd0);
    chk("mr slip2", 32'(sv2), 32'd0);
    chk("mr busy2", 32'(sb2), 32'd0);
    reset = 1'b0;
    gap = 0;
    do begin mgtword = $urandom; tick(); gap++; end while (!wv2 && gap < 10);
    chk("mr first valid", gap, 3);

    // randomized traffic
    for (int t = 0; t < 1200; t++) begin
      mgtword    = $urandom;
      phase_hold = ($urandom_range(0, 9) == 0);
      for (int c = 0; c < 4; c++) bitslip[c] = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
